pipe_ctrl_unit: RTL

Pipeline control unit for the 5-stage RV32I core. It takes the decoder's control bundle in ID and carries it through the ID/EX, EX/MEM and MEM/WB control registers. It resolves branches and jumps in EX, detects load-use hazards, and drives stall, flush and forwarding selects for the datapath. It sits between the combinational decoder and the datapath pipeline registers.

---
 rtl/pipe_ctrl_unit.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl_unit.sv
// Pipeline control for the 5-stage RV32I core: ID/EX, EX/MEM and MEM/WB control registers,
// EX branch resolution, load-use stall, flush and forwarding selects. PIPE_PERF_CNT_EN adds stall/flush counters.
module pipe_ctrl_unit #(
   parameter int CNT_W = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       RegWriteD,
   input  logic       MemWriteD,
   input  logic       JumpD,
   input  logic       BranchD,
   input  logic       JalrD,
   input  logic       ALUSrcD,
   input  logic [1:0] ResultSrcD,
   input  logic [2:0] ALUControlD,
   input  logic [2:0] func3D,
   input  logic [4:0] Rs1D,
   input  logic [4:0] Rs2D,
   input  logic [4:0] RdD,
   input  logic       ZeroE,
   input  logic       LtE,
   output logic       StallF,
   output logic       StallD,
   output logic       FlushD,
   output logic       FlushE,
   output logic [1:0] PCSrcE,
   output logic [1:0] ForwardAE,
   output logic [1:0] ForwardBE,
   output logic [2:0] ALUControlE,
   output logic       ALUSrcE,
   output logic       MemWriteM,
   output logic       RegWriteM,
   output logic [4:0] RdM,
   output logic [1:0] ResultSrcW,
   output logic       RegWriteW,
   output logic [4:0] RdW
`ifdef PIPE_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] StallCnt,
   output logic [CNT_W-1:0] FlushCnt
`endif
);

   typedef struct packed {
      logic       regwrite;
      logic       memwrite;
      logic       jump;
      logic       branch;
      logic       jalr;
      logic       alusrc;
      logic [1:0] resultsrc;
      logic [2:0] aluctl;
      logic [2:0] func3;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
   } idex_t;

   typedef struct packed {
      logic       regwrite;
      logic       memwrite;
      logic [1:0] resultsrc;
      logic [4:0] rd;
   } exmem_t;

   typedef struct packed {
      logic       regwrite;
      logic [1:0] resultsrc;
      logic [4:0] rd;
   } memwb_t;

   if (CNT_W < 1) begin : g_cnt_w_chk
      $error("CNT_W must be at least 1");
   end

   idex_t  d_bus, e_q;
   exmem_t m_q;
   memwb_t w_q;
   logic   cond, taken, lw_stall, redirect;

   assign d_bus = '{regwrite: RegWriteD, memwrite: MemWriteD, jump: JumpD, branch: BranchD,
                    jalr: JalrD, alusrc: ALUSrcD, resultsrc: ResultSrcD, aluctl: ALUControlD,
                    func3: func3D, rs1: Rs1D, rs2: Rs2D, rd: RdD};

   // Only ID/EX can take a bubble; everything past EX always advances.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         e_q <= '0;
         m_q <= '0;
         w_q <= '0;
      end else begin
         e_q <= FlushE ? idex_t'('0) : d_bus;
         m_q <= '{regwrite: e_q.regwrite, memwrite: e_q.memwrite, resultsrc: e_q.resultsrc, rd: e_q.rd};
         w_q <= '{regwrite: m_q.regwrite, resultsrc: m_q.resultsrc, rd: m_q.rd};
      end
   end

   always_comb begin
      cond = 1'b0;
      case (e_q.func3)
         3'b000:  cond = ZeroE;
         3'b001:  cond = ~ZeroE;
         3'b100:  cond = LtE;
         3'b101:  cond = ~LtE;
         default: cond = 1'b0;
      endcase
   end

   assign taken = e_q.branch & cond;

   always_comb begin
      PCSrcE = 2'b00;
      if (e_q.jalr)                PCSrcE = 2'b10;
      else if (e_q.jump || taken)  PCSrcE = 2'b01;
   end

   assign redirect = (PCSrcE != 2'b00);
   assign lw_stall = (e_q.resultsrc == 2'b01) && (e_q.rd != 5'd0) &&
                     ((e_q.rd == Rs1D) || (e_q.rd == Rs2D));

   assign StallF = lw_stall;
   assign StallD = lw_stall;
   assign FlushD = redirect;
   assign FlushE = lw_stall | redirect;

   // MEM beats WB; x0 is never a forwarding match.
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic rw_m, input logic [4:0] rd_m,
                                          input logic rw_w, input logic [4:0] rd_w);
      if (rw_m && (rd_m != 5'd0) && (rd_m == rs))      fwd_sel = 2'b10;
      else if (rw_w && (rd_w != 5'd0) && (rd_w == rs)) fwd_sel = 2'b01;
      else                                             fwd_sel = 2'b00;
   endfunction

   assign ForwardAE = fwd_sel(e_q.rs1, m_q.regwrite, m_q.rd, w_q.regwrite, w_q.rd);
   assign ForwardBE = fwd_sel(e_q.rs2, m_q.regwrite, m_q.rd, w_q.regwrite, w_q.rd);

   assign ALUControlE = e_q.aluctl;
   assign ALUSrcE     = e_q.alusrc;
   assign MemWriteM   = m_q.memwrite;
   assign RegWriteM   = m_q.regwrite;
   assign RdM         = m_q.rd;
   assign ResultSrcW  = w_q.resultsrc;
   assign RegWriteW   = w_q.regwrite;
   assign RdW         = w_q.rd;

`ifdef PIPE_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         StallCnt <= '0;
         FlushCnt <= '0;
      end else begin
         if (lw_stall) StallCnt <= StallCnt + {{(CNT_W-1){1'b0}}, 1'b1};
         if (redirect) FlushCnt <= FlushCnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end
`endif

endmodule
